uart_bus_responder: RTL
=======================

// Module: uart_bus_responder
// PURPOSE
// - Memory-mapped UART responder on the CPU data bus (rd/wr/addr/wdata/rdata), beside DataMem and Peripheral.
// - CPU initiates loads/stores; this block decodes its registers, answers same cycle, serialises TX bytes on dout,
//   deserialises din, and raises irqout for TX-done / RX-ready. 8N1 framing, LSB first.
// PARAMETERS
// - CLK_FREQ   50_000_000  core clock in Hz (the CPU bus clock).
// - BAUD       9600        line rate; DIV = CLK_FREQ/BAUD (integer, >=4; not checked in RTL).
// - BASE_ADDR  32'h40000018  byte address of the TXD register.
// PORTS
// - clk     in   1   bus clock; all state on rising edge.
// - reset   in   1   asynchronous, active-low; 0 = reset.
// - rd      in   1   bus read strobe.
// - wr      in   1   bus write strobe (sampled at clk edge).
// - addr    in   32  byte address; only word-aligned hits decode.
// - wdata   in   32  write data.
// - rdata   out  32  read data, combinational; 0 when !rd or no hit.
// - din     in   1   serial RX line, asynchronous, idle high.
// - dout    out  1   serial TX line, idle high.
// - irqout  out  1   level interrupt request.
// BEHAVIOUR
// - Map: BASE+0 TXD (W: wdata[7:0] send; R: last byte sent), BASE+4 RXD (R: {24'b0,rx_byte}),
//   BASE+8 CON: [0] tx_ie RW, [1] rx_ie RW, [2] tx_done R, [3] rx_valid R, [4] tx_busy R, [5] overrun R.
// - Reset values: dout=1, irqout=0, CON=0, tx/rx bytes=0, both FSMs IDLE, counters 0, synchroniser=2'b11.
// - Read: combinational, zero wait. Side effects commit at the clk edge where rd && hit:
//   read RXD clears rx_valid and overrun; read CON clears tx_done.
// - Write TXD when tx_busy=0: latch byte, tx_busy=1, start TX next cycle. When tx_busy=1: write ignored, no flag.
// - Write CON updates bits [1:0] only; status bits ignore writes.
// - TX FSM IDLE->START->DATA(8 bits)->STOP->IDLE; each state/bit held exactly DIV clocks.
//   dout: START=0, DATA=bit[i] LSB first, STOP=1. On STOP end: tx_busy=0, tx_done=1.
//   Frame = 10*DIV clocks; first 0 appears one cycle after the write edge.
// - RX: din through 2-FF synchroniser. IDLE: falling edge -> START, count DIV/2; still 0 at midpoint -> DATA,
//   else IDLE (glitch reject). DATA samples every DIV clocks at bit centre, 8 bits. STOP sampled:
//   1 -> rx_byte updated, rx_valid=1 (overrun=1 if rx_valid already 1); 0 -> frame discarded, no flag.
// - Same-edge RXD read and frame completion: new byte wins, rx_valid stays 1, overrun not set.
// - Same-edge CON read and TX completion: tx_done ends at 1.
// - irqout = (tx_ie & tx_done) | (rx_ie & rx_valid), registered from flags (flags are registers; irqout is comb of regs).
// - Reset mid-frame: both FSMs abort immediately, dout returns to 1 asynchronously.
// - Unaligned or unmapped addresses: no write effect, rdata=0.
// STRUCTURE
// - Shared package: register offsets (TXD=0, RXD=4, CON=8), CON bit indices, TX/RX state encodings.
// - One sub-module uart_rx_core (synchroniser + RX FSM, outputs byte/strobe/frame_err);
//   TX FSM and register file inline in uart_bus_responder.
// TESTING (CLK_FREQ=16, BAUD=1 -> DIV=16)
// - Reset: hold reset=0 mid-frame -> dout=1, irqout=0, read CON returns 0 after release.
// - TX: write TXD=0x55, CON=0x1 -> dout low 16 clks, then 1,0,1,0,1,0,1,0 each 16 clks, stop high 16; tx_done=1, irqout=1; read CON -> 0x05 then irqout=0.
// - TX busy: write 0xA5 then 0x3C 5 clks later -> only 0xA5 frame transmitted; TXD read returns 0xA5.
// - RX: CON=0x2, drive 8N1 frame 0xC3 on din -> RXD reads 0x000000C3, CON bit3=1, irqout=1; after RXD read, bit3=0, irqout=0.
// - RX errors: 4-clk low glitch on din -> no frame; frame 0x12 with stop=0 -> rx_valid stays 0; two frames unread -> RXD=second byte, overrun=1.
// - Decode: write/read BASE+12 and BASE+2 -> rdata=0, no state change; rd=0 at BASE+4 -> rdata=0, rx_valid unchanged.

Source files
------------

// File: rtl/uart_bus_responder_pkg.sv
// Shared definitions for the memory-mapped UART responder: register offsets,
// CON bit positions and the TX/RX state encodings.
package uart_bus_responder_pkg;

   localparam logic [31:0] OFF_TXD = 32'h0000_0000;
   localparam logic [31:0] OFF_RXD = 32'h0000_0004;
   localparam logic [31:0] OFF_CON = 32'h0000_0008;

   localparam int CON_TX_IE    = 0;
   localparam int CON_RX_IE    = 1;
   localparam int CON_TX_DONE  = 2;
   localparam int CON_RX_VALID = 3;
   localparam int CON_TX_BUSY  = 4;
   localparam int CON_OVERRUN  = 5;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   // Assemble the CON read word from its individual flags.
   function automatic logic [31:0] conWord(input logic txIe,
                                           input logic rxIe,
                                           input logic txDone,
                                           input logic rxValid,
                                           input logic txBusy,
                                           input logic overrun);
      logic [31:0] w;
      w               = '0;
      w[CON_TX_IE]    = txIe;
      w[CON_RX_IE]    = rxIe;
      w[CON_TX_DONE]  = txDone;
      w[CON_RX_VALID] = rxValid;
      w[CON_TX_BUSY]  = txBusy;
      w[CON_OVERRUN]  = overrun;
      return w;
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: two-flop synchroniser on the serial line, start-bit glitch
// rejection at the half-bit point and centre sampling of data and stop bits.
module uart_rx_core
   import uart_bus_responder_pkg::*;
#(
   parameter int DIV = 16
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_din,
   output logic [7:0] o_byte,
   output logic       o_strobe,
   output logic       o_frameErr
);

   localparam int            CW        = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   logic [1:0]    r_sync;
   logic          r_prev;
   rx_state_t     r_state;
   rx_state_t     w_stateNext;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cntNext;
   logic [2:0]    r_bit;
   logic [2:0]    w_bitNext;
   logic [7:0]    r_shift;
   logic [7:0]    w_shiftNext;
   logic          w_rxd;
   logic          w_cntEnd;

   assign w_rxd    = r_sync[1];
   assign w_cntEnd = (r_cnt == CNT_LAST);
   assign o_byte   = r_shift;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync  <= 2'b11;
         r_prev  <= 1'b1;
         r_state <= RX_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else begin
         r_sync  <= {r_sync[0], i_din};
         r_prev  <= w_rxd;
         r_state <= w_stateNext;
         r_cnt   <= w_cntNext;
         r_bit   <= w_bitNext;
         r_shift <= w_shiftNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_bitNext   = r_bit;
      w_shiftNext = r_shift;
      o_strobe    = 1'b0;
      o_frameErr  = 1'b0;
      case (r_state)
         RX_IDLE: begin
            if (r_prev && !w_rxd) begin
               w_stateNext = RX_START;
               w_cntNext   = '0;
            end
         end
         RX_START: begin
            // A start bit that is high again at its midpoint was only a glitch.
            if (r_cnt == HALF_LAST) begin
               w_cntNext   = '0;
               w_bitNext   = '0;
               w_stateNext = w_rxd ? RX_IDLE : RX_DATA;
            end else begin
               w_cntNext = r_cnt + CNT_ONE;
            end
         end
         RX_DATA: begin
            if (w_cntEnd) begin
               w_cntNext   = '0;
               w_shiftNext = {w_rxd, r_shift[7:1]};
               if (r_bit == 3'd7) begin
                  w_stateNext = RX_STOP;
               end else begin
                  w_bitNext = r_bit + 3'd1;
               end
            end else begin
               w_cntNext = r_cnt + CNT_ONE;
            end
         end
         RX_STOP: begin
            if (w_cntEnd) begin
               w_cntNext   = '0;
               w_stateNext = RX_IDLE;
               o_strobe    = w_rxd;
               o_frameErr  = ~w_rxd;
            end else begin
               w_cntNext = r_cnt + CNT_ONE;
            end
         end
         default: w_stateNext = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_bus_responder.sv
// CPU-bus UART responder: decodes TXD/RXD/CON, serialises TX bytes on dout,
// collects bytes from uart_rx_core and drives a level interrupt.
module uart_bus_responder
   import uart_bus_responder_pkg::*;
#(
   parameter int          CLK_FREQ  = 50_000_000,
   parameter int          BAUD      = 9600,
   parameter logic [31:0] BASE_ADDR = 32'h4000_0018
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        din,
   output logic        dout,
   output logic        irqout
);

   localparam int            DIV      = CLK_FREQ / BAUD;
   localparam int            CW       = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic          r_txIe;
   logic          r_rxIe;
   logic          r_txDone;
   logic          r_rxValid;
   logic          r_txBusy;
   logic          r_overrun;
   logic [7:0]    r_txByte;
   logic [7:0]    r_rxByte;

   tx_state_t     r_txState;
   tx_state_t     w_txStateNext;
   logic [CW-1:0] r_txCnt;
   logic [CW-1:0] w_txCntNext;
   logic [2:0]    r_txBit;
   logic [2:0]    w_txBitNext;
   logic          r_dout;
   logic          w_doutNext;
   logic          w_txFinish;
   logic          w_txCntEnd;

   logic          w_hitTxd;
   logic          w_hitRxd;
   logic          w_hitCon;
   logic          w_wrTxd;
   logic          w_wrCon;
   logic          w_rdRxd;
   logic          w_rdCon;

   logic [7:0]    w_rxByte;
   logic          w_rxStrobe;
   logic          w_rxFrameErr;
   logic          w_unused;

   // Exact address match only, so unaligned or unmapped accesses never hit.
   assign w_hitTxd = (addr == BASE_ADDR + OFF_TXD);
   assign w_hitRxd = (addr == BASE_ADDR + OFF_RXD);
   assign w_hitCon = (addr == BASE_ADDR + OFF_CON);
   assign w_wrTxd  = wr & w_hitTxd & ~r_txBusy;
   assign w_wrCon  = wr & w_hitCon;
   assign w_rdRxd  = rd & w_hitRxd;
   assign w_rdCon  = rd & w_hitCon;

   assign w_unused = ^{wdata[31:8], w_rxFrameErr};

   assign dout   = r_dout;
   assign irqout = (r_txIe & r_txDone) | (r_rxIe & r_rxValid);

   always_comb begin
      rdata = '0;
      if (rd) begin
         if (w_hitTxd) begin
            rdata = {24'b0, r_txByte};
         end else if (w_hitRxd) begin
            rdata = {24'b0, r_rxByte};
         end else if (w_hitCon) begin
            rdata = conWord(r_txIe, r_rxIe, r_txDone, r_rxValid, r_txBusy, r_overrun);
         end
      end
   end

   uart_rx_core #(
      .DIV(DIV)
   ) u_rx (
      .clk       (clk),
      .reset     (reset),
      .i_din     (din),
      .o_byte    (w_rxByte),
      .o_strobe  (w_rxStrobe),
      .o_frameErr(w_rxFrameErr)
   );

   // Completion events take priority over the clearing reads on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_txIe    <= 1'b0;
         r_rxIe    <= 1'b0;
         r_txDone  <= 1'b0;
         r_rxValid <= 1'b0;
         r_txBusy  <= 1'b0;
         r_overrun <= 1'b0;
         r_txByte  <= '0;
         r_rxByte  <= '0;
      end else begin
         if (w_wrCon) begin
            r_txIe <= wdata[CON_TX_IE];
            r_rxIe <= wdata[CON_RX_IE];
         end
         if (w_wrTxd) begin
            r_txByte <= wdata[7:0];
            r_txBusy <= 1'b1;
         end else if (w_txFinish) begin
            r_txBusy <= 1'b0;
         end
         if (w_txFinish) begin
            r_txDone <= 1'b1;
         end else if (w_rdCon) begin
            r_txDone <= 1'b0;
         end
         if (w_rxStrobe) begin
            r_rxByte  <= w_rxByte;
            r_rxValid <= 1'b1;
            r_overrun <= w_rdRxd ? 1'b0 : (r_overrun | r_rxValid);
         end else if (w_rdRxd) begin
            r_rxValid <= 1'b0;
            r_overrun <= 1'b0;
         end
      end
   end

   assign w_txCntEnd = (r_txCnt == CNT_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_txState <= TX_IDLE;
         r_txCnt   <= '0;
         r_txBit   <= '0;
         r_dout    <= 1'b1;
      end else begin
         r_txState <= w_txStateNext;
         r_txCnt   <= w_txCntNext;
         r_txBit   <= w_txBitNext;
         r_dout    <= w_doutNext;
      end
   end

   // dout is registered alongside the state so the line never glitches.
   always_comb begin
      w_txStateNext = r_txState;
      w_txCntNext   = r_txCnt;
      w_txBitNext   = r_txBit;
      w_doutNext    = r_dout;
      w_txFinish    = 1'b0;
      case (r_txState)
         TX_IDLE: begin
            w_doutNext = 1'b1;
            if (r_txBusy) begin
               w_txStateNext = TX_START;
               w_txCntNext   = '0;
               w_doutNext    = 1'b0;
            end
         end
         TX_START: begin
            if (w_txCntEnd) begin
               w_txStateNext = TX_DATA;
               w_txCntNext   = '0;
               w_txBitNext   = '0;
               w_doutNext    = r_txByte[0];
            end else begin
               w_txCntNext = r_txCnt + CNT_ONE;
            end
         end
         TX_DATA: begin
            if (w_txCntEnd) begin
               w_txCntNext = '0;
               if (r_txBit == 3'd7) begin
                  w_txStateNext = TX_STOP;
                  w_doutNext    = 1'b1;
               end else begin
                  w_txBitNext = r_txBit + 3'd1;
                  w_doutNext  = r_txByte[r_txBit + 3'd1];
               end
            end else begin
               w_txCntNext = r_txCnt + CNT_ONE;
            end
         end
         TX_STOP: begin
            if (w_txCntEnd) begin
               w_txStateNext = TX_IDLE;
               w_txCntNext   = '0;
               w_txFinish    = 1'b1;
            end else begin
               w_txCntNext = r_txCnt + CNT_ONE;
            end
         end
         default: w_txStateNext = TX_IDLE;
      endcase
   end

endmodule
